pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controller for the far end of an MMCM/PLL wrapper's rst/locked pair.
- Drives the PLL's rst, waits for lock with a timeout, and retries a bounded number of times.
- Qualifies lock as stable before releasing clocks_ready to downstream reset logic.
- Detects loss of lock and re-sequences. Runs on a free-running reference clock that never depends on the PLL it controls.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before an attempt fails (min 2).
- LOCK_STABLE, 1024: consecutive synced-locked cycles required before clocks_ready (min 1).
- MAX_RETRIES, 3: retries after the first attempt before FAILED (0-15).
- CNT_W, 17: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).

Ports:
- refclk, input, 1: free-running sequencer clock. The block has exactly one clock.
- rst, input, 1: reset, synchronous to refclk, active-high.
- enable, input, 1: level; high requests the PLL be brought up, low parks it in reset.
- pll_locked, input, 1: PLL locked output, asynchronous to refclk.
- pll_rst, output, 1: to PLL rst.
- clocks_ready, output, 1: PLL locked and stable.
- lock_lost, output, 1: single-cycle pulse when lock drops while READY.
- fail, output, 1: retries exhausted.
- retry_count, output, 4: retries used in the current bring-up.
- state, output, 3: current state encoding, for debug.

Behaviour:
- **Lock synchroniser.** pll_locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency). Only locked_s is used internally.
- **Registers.** All outputs are registered. One counter cnt[CNT_W-1:0] is cleared on every state transition.
- **Reset.** While rst is high on an edge: state=IDLE, pll_rst=1, clocks_ready=0, lock_lost=0, fail=0, retry_count=0, cnt=0, synchroniser flops=0. Reset mid-sequence takes effect on the next edge regardless of state.
- **State encodings:** IDLE=0, RESET=1, WAIT_LOCK=2, STABLE=3, READY=4, FAILED=5.
- **enable low.** Overrides every state: next state is IDLE, pll_rst=1, clocks_ready=0. fail and retry_count clear on entering IDLE.
- **IDLE.** pll_rst=1. If enable is high, go to RESET.
- **RESET.** pll_rst=1. When cnt==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly RST_CYCLES cycles.
- **WAIT_LOCK.** pll_rst=0.
  - locked_s high: go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT-1: if retry_count==MAX_RETRIES go to FAILED; otherwise increment retry_count and go to RESET.
- **STABLE.** pll_rst=0.
  - locked_s low: counts as a failed attempt, with the same retry/FAILED rule as the WAIT_LOCK timeout.
  - Else, when cnt==LOCK_STABLE-1: go to READY.
- **READY.** clocks_ready=1, pll_rst=0. retry_count clears on entry.
  - If locked_s goes low: lock_lost=1 for exactly one cycle, clocks_ready=0, go to RESET with retry_count=0 (fresh bring-up).
- **FAILED.** pll_rst=1, fail=1, clocks_ready=0. Holds until enable goes low (then IDLE) or rst.
- **Output registration.** Outputs reflect the new state in the cycle the state register takes it, i.e. output registers are loaded from next-state decode.
- **Simultaneous events.** enable low has priority over all transitions, including a same-cycle timeout, lock loss, or a lock_lost pulse (the pulse is suppressed). The lock-loss check has priority over the stable-count completion in STABLE.
- **Counter.** Never wraps in use. Comparisons are exact equality, and cnt clears on every transition.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2):
- **Nominal bring-up.** rst released, enable high at edge 0, pll_locked high from cycle 10 -> pll_rst high cycles 1-4, low from 5; STABLE at 13; clocks_ready=1 from cycle 21; retry_count=0, fail=0.
- **Never locks.** pll_locked tied 0, enable high -> three attempts of 4+20 cycles, each with pll_rst high for 4; retry_count steps 0,1,2; FAILED with fail=1 and pll_rst=1 at cycle 73; holds indefinitely; enable low -> IDLE, fail=0, retry_count=0.
- **Glitch during STABLE.** pll_locked drops for 3 cycles at cycle 3 of STABLE -> back to RESET, retry_count=1, pll_rst high 4 cycles; then lock holds -> clocks_ready=1 and retry_count=0.
- **Lock loss in READY.** After clocks_ready=1, drop pll_locked -> 2 cycles later lock_lost pulses for exactly 1 cycle, clocks_ready=0 and pll_rst=1 that same cycle; re-lock -> clocks_ready returns after 4+sync+8 cycles.
- **enable low collision.** Deassert enable on the exact WAIT_LOCK timeout cycle with retry_count=2 -> IDLE, not FAILED; fail=0, pll_rst=1.
- **Reset mid-operation.** Assert rst for 1 cycle while in READY -> next cycle all outputs at reset values, and bring-up restarts from IDLE with enable still high.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Brings up an MMCM/PLL from a free-running reference clock: pulses its reset, waits
// for lock with a timeout and bounded retries, and qualifies lock as stable before clocks_ready.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       clocks_ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_READY     = 3'd4,
        S_FAILED    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync1_q, sync2_q;
    logic             pll_rst_q, ready_q, lost_q, fail_q;
    logic             lost_d, attempt_fail;
    logic             locked_s;

    assign locked_s = sync2_q;

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        lost_d       = 1'b0;
        attempt_fail = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_RESET;
                S_RESET: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (locked_s)                   state_d = S_STABLE;
                    else if (cnt_q == TIMEOUT_LAST) attempt_fail = 1'b1;
                end
                // Lock dropping out wins over a same-cycle stable-count completion.
                S_STABLE: begin
                    if (!locked_s)                 attempt_fail = 1'b1;
                    else if (cnt_q == STABLE_LAST) state_d = S_READY;
                end
                S_READY: begin
                    if (!locked_s) begin
                        state_d = S_RESET;
                        retry_d = 4'd0;
                        lost_d  = 1'b1;
                    end
                end
                S_FAILED: state_d = S_FAILED;
                default:  state_d = S_IDLE;
            endcase
            if (attempt_fail) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = S_FAILED;
                end else begin
                    state_d = S_RESET;
                    retry_d = retry_q + 4'd1;
                end
            end
        end
        if (state_d == S_IDLE || state_d == S_READY) retry_d = 4'd0;
    end

    // Only the timed states count; the counter restarts on every transition.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == S_RESET || state_q == S_WAIT_LOCK || state_q == S_STABLE))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= 4'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            lost_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            sync1_q   <= pll_locked;
            sync2_q   <= sync1_q;
            pll_rst_q <= (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_FAILED);
            ready_q   <= (state_d == S_READY);
            lost_q    <= lost_d;
            fail_q    <= (state_d == S_FAILED);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign clocks_ready = ready_q;
    assign lock_lost    = lost_q;
    assign fail         = fail_q;
    assign retry_count  = retry_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters; cycle n is the
// interval after rising edge n, edge 0 being the last edge with rst high.
module tb_pll_lock_sequencer;

    localparam int ST_IDLE = 0, ST_RESET = 1, ST_WAIT = 2, ST_STABLE = 3, ST_READY = 4, ST_FAILED = 5;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, clocks_ready, lock_lost, fail;
    logic [3:0] retry_count;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pll_lock_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRIES(2), .CNT_W(8)
    ) dut (
        .refclk(refclk), .rst(rst), .enable(enable), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .clocks_ready(clocks_ready), .lock_lost(lock_lost),
        .fail(fail), .retry_count(retry_count), .state(state)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Holds rst for three edges with enable low, then releases both at cycle 0.
    task automatic restart(input logic locked0);
        rst = 1'b1;
        enable = 1'b0;
        pll_locked = locked0;
        repeat (3) @(posedge refclk);
        #1;
        rst = 1'b0;
        enable = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_all(input string tag, input int st, input logic prst, input logic rdy,
                           input logic lost, input logic fl, input int rc);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(prst));
        chk({tag, ".clocks_ready"}, 32'(clocks_ready), 32'(rdy));
        chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(lost));
        chk({tag, ".fail"}, 32'(fail), 32'(fl));
        chk({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
    endtask

    initial begin
        int exp_st, a, off;

        // Reset values.
        repeat (3) @(posedge refclk);
        #1;
        chk_all("reset", ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Nominal bring-up: lock from cycle 10.
        restart(1'b0);
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (cyc == 10) pll_locked = 1'b1;
            exp_st = (cyc <= 4) ? ST_RESET : (cyc <= 12) ? ST_WAIT : (cyc <= 20) ? ST_STABLE : ST_READY;
            chk("nom.state", 32'(state), 32'(exp_st));
            chk("nom.pll_rst", 32'(pll_rst), 32'(cyc <= 4));
            chk("nom.clocks_ready", 32'(clocks_ready), 32'(cyc >= 21));
        end
        chk_all("nom.end", ST_READY, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Never locks: three 24-cycle attempts, FAILED at 73.
        restart(1'b0);
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (cyc <= 72) begin
                a = (cyc - 1) / 24;
                off = (cyc - 1) % 24;
                chk("nolock.state", 32'(state), 32'((off < 4) ? ST_RESET : ST_WAIT));
                chk("nolock.pll_rst", 32'(pll_rst), 32'(off < 4));
                chk("nolock.retry", 32'(retry_count), 32'(a));
                chk("nolock.fail", 32'(fail), 32'd0);
            end else begin
                chk_all("nolock.failed", ST_FAILED, 1'b1, 1'b0, 1'b0, 1'b1, 2);
            end
        end
        enable = 1'b0;
        tick();
        chk_all("nolock.disable", ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Glitch during STABLE: pll_locked low for cycles 15..17.
        restart(1'b0);
        step_to(10);
        pll_locked = 1'b1;
        step_to(13);
        chk("glitch.in_stable", 32'(state), ST_STABLE);
        step_to(15);
        pll_locked = 1'b0;
        step_to(17);
        chk("glitch.still_stable", 32'(state), ST_STABLE);
        step_to(18);
        pll_locked = 1'b1;
        chk_all("glitch.retry", ST_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        step_to(21);
        chk("glitch.rst_hold", 32'(pll_rst), 32'd1);
        step_to(22);
        chk_all("glitch.wait", ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step_to(23);
        chk("glitch.stable2", 32'(state), ST_STABLE);
        step_to(30);
        chk_all("glitch.pre_ready", ST_STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step_to(31);
        chk_all("glitch.ready", ST_READY, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Lock loss in READY: drop after edge 33, pulse at 36, re-lock ready at 49.
        step_to(33);
        pll_locked = 1'b0;
        step_to(35);
        chk_all("loss.pre", ST_READY, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step_to(36);
        pll_locked = 1'b1;
        chk_all("loss.pulse", ST_RESET, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        step_to(37);
        chk("loss.pulse_end", 32'(lock_lost), 32'd0);
        step_to(40);
        chk("loss.wait", 32'(state), ST_WAIT);
        step_to(41);
        chk("loss.stable", 32'(state), ST_STABLE);
        step_to(48);
        chk("loss.pre_ready", 32'(clocks_ready), 32'd0);
        step_to(49);
        chk_all("loss.ready", ST_READY, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // enable drops on the final timeout edge with retry_count at its limit.
        restart(1'b0);
        step_to(72);
        chk_all("coll.pre", ST_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        enable = 1'b0;
        tick();
        chk_all("coll.idle", ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick();
        chk("coll.stay_idle", 32'(state), ST_IDLE);

        // One-cycle rst while READY, enable stays high.
        restart(1'b1);
        step_to(25);
        chk("mrst.ready", 32'(clocks_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        chk_all("mrst.reset", ST_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step_to(1);
        chk_all("mrst.restart", ST_RESET, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step_to(5);
        chk("mrst.wait", 32'(state), ST_WAIT);
        step_to(6);
        chk("mrst.stable", 32'(state), ST_STABLE);
        step_to(13);
        chk("mrst.pre_ready", 32'(clocks_ready), 32'd0);
        step_to(14);
        chk_all("mrst.ready2", ST_READY, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
